// File: rtl/stack_access_ctrl_if.sv
// Request/response, stack-pointer and data-memory signals of the stack access controller.
// The slave modport is the controller; the master modport is its environment.
interface stack_access_ctrl_if #(
    parameter int ADDR_W = 20
);
    logic              req_valid;
    logic [1:0]        req_op;
    logic [31:0]       req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [31:0]       sp_in;
    logic [2:0]        sp_ctrl;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [15:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output req_valid, req_op, req_wdata, sp_in, mem_rdata, mem_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, sp_ctrl,
               mem_addr, mem_wdata, mem_we, mem_re
    );

    modport slave (
        input  req_valid, req_op, req_wdata, sp_in, mem_rdata, mem_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, sp_ctrl,
               mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/stack_access_ctrl.sv
// Sequences 16/32-bit stack push/pop over a 16-bit memory port; resp_valid 3 (16b) / 4 (32b) cycles after accept
// with zero-wait memory, 2 on a range error. Strobes hold until mem_ready; one request in flight, req_ready only in IDLE.
module stack_access_ctrl #(
    parameter int          ADDR_W    = 20,
    parameter logic [31:0] STACK_TOP = 32'd1048575
) (
    input  logic               clk,
    input  logic               Rst,
    stack_access_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, XFER0, XFER1, ADJ, DONE} state_t;

    localparam logic [1:0] OP_PUSH16 = 2'b00;
    localparam logic [1:0] OP_POP16  = 2'b01;
    localparam logic [1:0] OP_PUSH32 = 2'b10;

    state_t            state;
    logic [1:0]        op_q;
    logic [15:0]       lo_wdata_q;
    logic [ADDR_W-1:0] base_q;
    logic [15:0]       lo_word;
    logic [32:0]       sp_ext;
    logic              range_bad;
    logic [ADDR_W-1:0] sp_addr;

    assign sp_addr = bus.sp_in[ADDR_W-1:0];

    // Bounds are evaluated on the live SP in 33 bits so neither end can wrap.
    always_comb begin
        range_bad = 1'b0;
        sp_ext    = {1'b0, bus.sp_in};
        unique case (bus.req_op)
            OP_PUSH16: range_bad = sp_ext < 33'd1;
            OP_PUSH32: range_bad = sp_ext < 33'd2;
            OP_POP16:  range_bad = (sp_ext + 33'd1) > {1'b0, STACK_TOP};
            default:   range_bad = (sp_ext + 33'd2) > {1'b0, STACK_TOP};
        endcase
    end

    function automatic logic [2:0] adj_code(input logic [1:0] op);
        unique case (op)
            OP_PUSH16: adj_code = 3'b100;
            OP_POP16:  adj_code = 3'b011;
            OP_PUSH32: adj_code = 3'b010;
            default:   adj_code = 3'b001;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (Rst) begin
            state          <= IDLE;
            op_q           <= 2'b00;
            lo_wdata_q     <= 16'h0000;
            base_q         <= '0;
            lo_word        <= 16'h0000;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'h0000_0000;
            bus.sp_ctrl    <= 3'b000;
            bus.mem_we     <= 1'b0;
            bus.mem_re     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= 16'h0000;
        end else begin
            bus.sp_ctrl    <= 3'b000;
            bus.resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q          <= bus.req_op;
                        lo_wdata_q    <= bus.req_wdata[15:0];
                        base_q        <= sp_addr;
                        bus.req_ready <= 1'b0;
                        bus.resp_err  <= range_bad;
                        // A rejected request still passes through ADJ (with a hold code) so the
                        // error response lands at a fixed point after accept.
                        if (range_bad) begin
                            state <= ADJ;
                        end else begin
                            state         <= XFER0;
                            bus.mem_we    <= ~bus.req_op[0];
                            bus.mem_re    <= bus.req_op[0];
                            bus.mem_addr  <= bus.req_op[0] ? sp_addr + ADDR_W'(1) : sp_addr;
                            bus.mem_wdata <= bus.req_op[1] ? bus.req_wdata[31:16] : bus.req_wdata[15:0];
                        end
                    end
                end
                XFER0: begin
                    if (bus.mem_ready) begin
                        lo_word <= bus.mem_rdata;
                        if (op_q[1]) begin
                            state         <= XFER1;
                            bus.mem_addr  <= op_q[0] ? base_q + ADDR_W'(2) : base_q - ADDR_W'(1);
                            bus.mem_wdata <= lo_wdata_q;
                        end else begin
                            state       <= ADJ;
                            bus.mem_we  <= 1'b0;
                            bus.mem_re  <= 1'b0;
                            bus.sp_ctrl <= adj_code(op_q);
                            if (op_q[0]) bus.resp_rdata <= {16'h0000, bus.mem_rdata};
                        end
                    end
                end
                XFER1: begin
                    if (bus.mem_ready) begin
                        state       <= ADJ;
                        bus.mem_we  <= 1'b0;
                        bus.mem_re  <= 1'b0;
                        bus.sp_ctrl <= adj_code(op_q);
                        if (op_q[0]) bus.resp_rdata <= {bus.mem_rdata, lo_word};
                    end
                end
                ADJ: begin
                    state          <= DONE;
                    bus.resp_valid <= 1'b1;
                end
                DONE: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
